// File: rtl/see_weight_loader_if.sv
// Command, byte-stream and BRAM write-port bundle for the SEE weight loader.
// The master side is the command/byte source; the slave side is the loader.
interface see_weight_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                     i_start;
  logic [ADDR_W-1:0]        i_base_addr;
  logic [ADDR_W:0]          i_word_cnt;
  logic                     i_abort;
  logic                     s_byte_valid;
  logic [7:0]               s_byte_data;
  logic                     s_byte_ready;
  logic                     o_wr_en_b;
  logic [ADDR_W-1:0]        o_wr_addr_b;
  logic signed [DATA_W-1:0] o_wr_data_b;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;

  modport master (
    output i_start, i_base_addr, i_word_cnt, i_abort, s_byte_valid, s_byte_data,
    input  s_byte_ready, o_wr_en_b, o_wr_addr_b, o_wr_data_b, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_base_addr, i_word_cnt, i_abort, s_byte_valid, s_byte_data,
    output s_byte_ready, o_wr_en_b, o_wr_addr_b, o_wr_data_b, o_busy, o_done, o_err
  );
endinterface

// File: rtl/see_weight_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to
// consecutive addresses of the weight BRAM's port B.
module see_weight_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  see_weight_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [1:0]               lane_reg, lane_next;
  logic [2:0][7:0]          pack_reg, pack_next;
  logic [ADDR_W:0]          word_idx_reg, word_idx_next;
  logic [ADDR_W:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]        base_reg, base_next;
  logic                     wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]        wr_addr_reg, wr_addr_next;
  logic signed [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic                     done_reg, done_next;
  logic                     err_reg, err_next;

  logic                     ready;
  logic                     handshake;
  logic [ADDR_W+1:0]        end_sum;

  assign ready     = (state_reg == LOAD);
  assign handshake = ready && bus.s_byte_valid;
  // Extra headroom bits so base + count can exceed DEPTH without wrapping.
  assign end_sum   = {2'b00, bus.i_base_addr} + {1'b0, bus.i_word_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      pack_reg     <= '0;
      word_idx_reg <= '0;
      cnt_reg      <= '0;
      base_reg     <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      pack_reg     <= pack_next;
      word_idx_reg <= word_idx_next;
      cnt_reg      <= cnt_next;
      base_reg     <= base_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lane_next     = lane_reg;
    pack_next     = pack_reg;
    word_idx_next = word_idx_reg;
    cnt_next      = cnt_reg;
    base_next     = base_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_word_cnt == '0) begin
            done_next = 1'b1;
          end else if (end_sum > (ADDR_W+2)'(DEPTH)) begin
            err_next = 1'b1;
          end else begin
            base_next     = bus.i_base_addr;
            cnt_next      = bus.i_word_cnt;
            lane_next     = '0;
            word_idx_next = '0;
            pack_next     = '0;
            state_next    = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.i_abort) begin
          // Partial word is dropped; a coincident lane-3 byte never writes.
          lane_next  = '0;
          pack_next  = '0;
          state_next = IDLE;
        end else if (handshake) begin
          if (lane_reg == 2'd3) begin
            wr_en_next    = 1'b1;
            wr_addr_next  = base_reg + word_idx_reg[ADDR_W-1:0];
            wr_data_next  = {bus.s_byte_data, pack_reg[2], pack_reg[1], pack_reg[0]};
            lane_next     = '0;
            word_idx_next = word_idx_reg + (ADDR_W+1)'(1);
            if (word_idx_reg == cnt_reg - (ADDR_W+1)'(1)) begin
              state_next = FLUSH;
            end
          end else begin
            pack_next[lane_reg] = bus.s_byte_data;
            lane_next           = lane_reg + 2'd1;
          end
        end
      end
      FLUSH: begin
        state_next = bus.i_abort ? IDLE : DONE;
        done_next  = !bus.i_abort;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.s_byte_ready = ready;
  assign bus.o_wr_en_b    = wr_en_reg;
  assign bus.o_wr_addr_b  = wr_addr_reg;
  assign bus.o_wr_data_b  = wr_data_reg;
  assign bus.o_busy       = (state_reg != IDLE);
  assign bus.o_done       = done_reg;
  assign bus.o_err        = err_reg;
endmodule
